// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and grant helper for the memory arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic {REQ_I, REQ_D} req_t;
   typedef enum logic {OP_RD, OP_WR} op_t;
   // On a tie the requester that was not served last wins
   function automatic req_t rr_pick(input logic i_act, input logic d_act, input req_t last);
      return (i_act && d_act) ? (last == REQ_I ? REQ_D : REQ_I) : (d_act ? REQ_D : REQ_I);
   endfunction
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: saturating count of BUSY cycles, flags an unanswered transaction
module mem_arb_watchdog #(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
   logic [W-1:0] count;
   always_ff @(posedge clk)
      if (rst || clr) count <= '0;
      else if (en && count != LAST) count <= count + 1'b1;
   assign expired = count == LAST;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between icache and dcache
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 128,
   parameter int TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rd,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              err
);
   state_t state, state_nx;
   req_t id, id_nx, last, last_nx, pick;
   op_t op, op_nx;
   logic abort, abort_nx, wd_clr, wd_en, expired, cap, i_act, d_act;
   logic [ADDR_W-1:0] addr_nx;
   logic [LINE_W-1:0] wdata_nx;
   assign i_act = i_rd | i_wr;
   assign d_act = d_rd | d_wr;
   assign pick = rr_pick(i_act, d_act, last);
   mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk(clk),
      .rst(rst),
      .clr(wd_clr),
      .en(wd_en),
      .expired(expired)
   );
   always_comb begin
      state_nx = state;
      id_nx = id;
      op_nx = op;
      last_nx = last;
      abort_nx = abort;
      addr_nx = mem_addr;
      wdata_nx = mem_wdata;
      wd_clr = 1'b0;
      wd_en = 1'b0;
      cap = 1'b0;
      case (state)
         IDLE: if (i_act || d_act) begin
            state_nx = BUSY;
            id_nx = pick;
            last_nx = pick;
            abort_nx = 1'b0;
            wd_clr = 1'b1;
            op_nx = (pick == REQ_D ? d_wr : i_wr) ? OP_WR : OP_RD;
            addr_nx = pick == REQ_D ? d_addr : i_addr;
            wdata_nx = pick == REQ_D ? d_wdata : i_wdata;
         end
         BUSY: begin
            wd_en = 1'b1;
            if (mem_resp) begin
               state_nx = DONE;
               cap = op == OP_RD;
            end else if (expired) begin
               state_nx = DONE;
               abort_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
   // Outputs are registered from the next-state values so they change on the same edge as the state
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         id <= REQ_I;
         op <= OP_RD;
         last <= REQ_I;
         abort <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_read <= 1'b0;
         mem_write <= 1'b0;
         i_resp <= 1'b0;
         d_resp <= 1'b0;
         err <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         state <= state_nx;
         id <= id_nx;
         op <= op_nx;
         last <= last_nx;
         abort <= abort_nx;
         mem_addr <= addr_nx;
         mem_wdata <= wdata_nx;
         mem_read <= state_nx == BUSY && op_nx == OP_RD;
         mem_write <= state_nx == BUSY && op_nx == OP_WR;
         i_resp <= state_nx == DONE && id_nx == REQ_I;
         d_resp <= state_nx == DONE && id_nx == REQ_D;
         err <= state_nx == DONE && abort_nx;
         if (cap && id == REQ_I) i_rdata <= mem_rdata;
         if (cap && id == REQ_D) d_rdata <= mem_rdata;
      end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int LW = 128;
   localparam int TO = 8;
   logic clk = 0;
   logic rst = 1;
   logic i_rd, i_wr, d_rd, d_wr, mem_resp;
   logic [AW-1:0] i_addr, d_addr, mem_addr;
   logic [LW-1:0] i_wdata, d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
   logic i_resp, d_resp, mem_read, mem_write, err;
   int tests = 0, fails = 0;
   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .err(err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_s(input string name, input string act, input string exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
      end
   endtask
   function automatic logic [LW-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   // Model: one transaction at a time; command lasts until mem_resp or TO cycles,
   // then one response cycle and one quiet cycle before the next grant.
   logic [LW-1:0] e_rdata [2];
   logic [AW-1:0] e_addr;
   logic [LW-1:0] e_wdata;
   logic e_rd, e_wr, e_iresp, e_dresp, e_err;
   bit m_last, m_active, m_gap, m_who, m_write, chk_en = 0;
   int m_age;
   always @(posedge clk) begin
      if (rst) begin
         e_rdata[0] = '0; e_rdata[1] = '0; e_addr = '0; e_wdata = '0;
         e_rd = 0; e_wr = 0; e_iresp = 0; e_dresp = 0; e_err = 0;
         m_last = 0; m_active = 0; m_gap = 0;
      end else begin
         e_iresp = 0; e_dresp = 0; e_err = 0;
         if (m_active) begin
            m_age++;
            if (mem_resp || m_age == TO) begin
               m_active = 0; m_gap = 1; e_rd = 0; e_wr = 0;
               e_iresp = !m_who; e_dresp = m_who; e_err = !mem_resp;
               if (mem_resp && !m_write) e_rdata[m_who] = mem_rdata;
            end
         end else if (m_gap) m_gap = 0;
         else if (i_rd || i_wr || d_rd || d_wr) begin
            m_who = ((i_rd || i_wr) && (d_rd || d_wr)) ? !m_last : (d_rd || d_wr);
            m_last = m_who; m_active = 1; m_age = 0;
            m_write = m_who ? d_wr : i_wr;
            e_addr = m_who ? d_addr : i_addr;
            e_wdata = m_who ? d_wdata : i_wdata;
            e_rd = !m_write; e_wr = m_write;
         end
      end
   end
   always @(negedge clk) if (chk_en) begin
      chk("mem_read", mem_read, e_rd);
      chk("mem_write", mem_write, e_wr);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("i_resp", i_resp, e_iresp);
      chk("d_resp", d_resp, e_dresp);
      chk("err", err, e_err);
      chk("i_rdata", i_rdata, e_rdata[0]);
      chk("d_rdata", d_rdata, e_rdata[1]);
   end
   bit r_on [2], r_rd [2], r_wr [2];
   logic [AW-1:0] r_addr [2];
   logic [LW-1:0] r_data [2];
   bit auto_req = 0, mute = 0, use_fix = 0, prev_cmd = 0, first_wr;
   int p_req = 0, mem_lat = 0, cur_lat = 1, cmd_cyc = 0, stray_pct = 0;
   logic [LW-1:0] fix_data = '0;
   int n_resp [2];
   int n_rd_cyc, n_wr_cyc, n_err, n_err_i, n_cmd;
   logic [AW-1:0] first_addr;
   string order;
   task automatic drive();
      i_rd = r_on[0] && r_rd[0]; i_wr = r_on[0] && r_wr[0];
      d_rd = r_on[1] && r_rd[1]; d_wr = r_on[1] && r_wr[1];
      i_addr = r_addr[0]; i_wdata = r_data[0];
      d_addr = r_addr[1]; d_wdata = r_data[1];
   endtask
   task automatic clear_obs();
      n_resp = '{0, 0}; n_rd_cyc = 0; n_wr_cyc = 0; n_err = 0; n_err_i = 0; n_cmd = 0;
      first_addr = '0; first_wr = 0; order = "";
   endtask
   task automatic tick();
      bit resp [2];
      int r;
      @(posedge clk);
      #1;
      resp[0] = i_resp; resp[1] = d_resp;
      if (i_resp) begin n_resp[0]++; order = {order, "I"}; end
      if (d_resp) begin n_resp[1]++; order = {order, "D"}; end
      if (err) begin n_err++; if (i_resp) n_err_i++; end
      if (mem_read) n_rd_cyc++;
      if (mem_write) n_wr_cyc++;
      if ((mem_read || mem_write) && !prev_cmd) begin
         if (n_cmd == 0) begin first_addr = mem_addr; first_wr = mem_write; end
         n_cmd++;
      end
      prev_cmd = mem_read || mem_write;
      mem_resp = 0;
      if (mem_read || mem_write) begin
         cmd_cyc++;
         if (cmd_cyc == 1) cur_lat = mem_lat != 0 ? mem_lat : int'($urandom_range(1, 10));
         if (!mute && cmd_cyc == cur_lat) begin
            mem_resp = 1;
            mem_rdata = use_fix ? fix_data : rnd_line();
         end
      end else begin
         cmd_cyc = 0;
         if ($urandom_range(99) < stray_pct) begin mem_resp = 1; mem_rdata = rnd_line(); end
      end
      // Requesters drop right after their response, optionally re-requesting a cycle later
      for (int k = 0; k < 2; k++)
         if (r_on[k] && resp[k]) r_on[k] = 0;
         else if (!r_on[k] && auto_req && $urandom_range(99) < p_req) begin
            r = int'($urandom_range(9));
            r_on[k] = 1; r_wr[k] = r < 4; r_rd[k] = r >= 4 || r == 0;
            r_addr[k] = {$urandom} & 32'hFFFF_FFF0; r_data[k] = rnd_line();
         end
      drive();
   endtask
   task automatic req(input int k, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] w);
      r_on[k] = 1; r_rd[k] = rd; r_wr[k] = wr; r_addr[k] = a; r_data[k] = w;
      drive();
   endtask
   task automatic wait_resp(input int k, input int want, input string name);
      int c = 0;
      while (n_resp[k] < want && c < 200) begin tick(); c++; end
      tests++;
      if (n_resp[k] < want) begin
         fails++;
         $display("FAIL %s: got %0d responses expected %0d within 200 cycles", name, n_resp[k], want);
      end
   endtask
   task automatic do_reset();
      rst = 1; r_on = '{0, 0}; drive();
      tick(); tick();
      rst = 0; clear_obs();
   endtask
   initial begin
      mem_resp = 0; mem_rdata = '0;
      r_on = '{0, 0}; r_rd = '{0, 0}; r_wr = '{0, 0};
      r_addr[0] = '0; r_addr[1] = '0; r_data[0] = '0; r_data[1] = '0;
      drive();
      tick();
      chk_en = 1;
      tick();
      rst = 0; clear_obs();
      chk("reset mem_read", mem_read, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset d_rdata", d_rdata, 0);
      chk("reset err", err, 0);
      mem_lat = 4; use_fix = 1; fix_data = {4{32'hDEADBEEF}};
      req(1, 1, 0, 32'h100, '0);
      wait_resp(1, 1, "single read resp");
      tick(); tick();
      chk("single read cycles", n_rd_cyc, 4);
      chk("single read addr", first_addr, 32'h100);
      chk("single read d_rdata", d_rdata, {4{32'hDEADBEEF}});
      chk("single read model pin", e_rdata[1], {4{32'hDEADBEEF}});
      chk("single read i_resp count", n_resp[0], 0);
      chk("single read d_resp count", n_resp[1], 1);
      do_reset(); use_fix = 0; mem_lat = 3;
      req(0, 1, 0, 32'h200, '0);
      req(1, 0, 1, 32'h300, {4{32'hCAFEF00D}});
      wait_resp(0, 1, "tie icache resp");
      tick(); tick();
      chk_s("tie order", order, "DI");
      chk("tie first is write", first_wr, 1);
      chk("tie first addr", first_addr, 32'h300);
      do_reset(); auto_req = 1; p_req = 100; mem_lat = 0;
      for (int c = 0; c < 600 && order.len() < 6; c++) tick();
      auto_req = 0;
      chk_s("contention order", order, "DIDIDI");
      repeat (40) tick();
      do_reset(); mem_lat = 2; use_fix = 1; fix_data = {4{32'h12345678}};
      req(0, 1, 0, 32'h40, '0);
      wait_resp(0, 1, "watchdog prime resp");
      tick(); tick();
      clear_obs(); mute = 1;
      req(0, 1, 0, 32'h80, '0);
      wait_resp(0, 1, "watchdog abort resp");
      tick(); tick();
      chk("watchdog read cycles", n_rd_cyc, TO);
      chk("watchdog err with i_resp", n_err_i, 1);
      chk("watchdog err count", n_err, 1);
      chk("watchdog i_rdata kept", i_rdata, {4{32'h12345678}});
      chk("watchdog model pin", e_rdata[0], {4{32'h12345678}});
      use_fix = 0;
      do_reset(); mute = 1;
      req(1, 0, 1, 32'h400, {4{32'h0BADC0DE}});
      for (int c = 0; c < 20 && n_wr_cyc < 2; c++) tick();
      rst = 1; r_on[1] = 0; drive();
      tick();
      chk("mid reset mem_write", mem_write, 0);
      chk("mid reset mem_addr", mem_addr, 0);
      chk("mid reset d_resp", d_resp, 0);
      rst = 0; mute = 0; stray_pct = 100;
      repeat (4) tick();
      stray_pct = 0;
      chk("mid reset no resp", n_resp[0] + n_resp[1], 0);
      chk("stray resp no command", n_cmd, 1);
      mem_lat = 3;
      req(1, 0, 1, 32'h500, {4{32'h55AA55AA}});
      wait_resp(1, 1, "post reset write resp");
      tick(); tick();
      clear_obs();
      req(1, 1, 1, 32'h600, {4{32'h600D600D}});
      wait_resp(1, 1, "illegal request resp");
      tick(); tick();
      chk("illegal read cycles", n_rd_cyc, 0);
      chk("illegal write cycles", n_wr_cyc, 3);
      do_reset(); auto_req = 1; p_req = 35; mem_lat = 0; stray_pct = 10;
      for (int n = 0; n < 3000; n++) begin
         tick();
         if ($urandom_range(499) == 0) begin rst = 1; r_on = '{0, 0}; drive(); end
         else rst = 0;
      end
      rst = 0; auto_req = 0; stray_pct = 0;
      repeat (40) tick();
      chk("soak responses seen", (n_resp[0] + n_resp[1]) > 50, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single main-memory port between the instruction-cache and data-cache controllers. It accepts line-sized read (fill) and write (writeback) requests from each cache FSM and serialises them onto one memory transaction at a time. Requests that arrive together are granted round-robin. Each transaction returns a one-cycle response pulse to its requester, and a watchdog aborts transactions whose memory never answers.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 128, cache line width in bits
- TIMEOUT, 256, max cycles in BUSY before abort; must be ≥ 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_rd, i_wr  in  1 each  icache read / write request, level
- i_addr  in  ADDR_W  icache line address
- i_wdata  in  LINE_W  icache write data
- i_rdata  out  LINE_W  icache read data, registered
- i_resp  out  1  icache transaction done, 1-cycle pulse
- d_rd, d_wr, d_addr, d_wdata, d_rdata, d_resp: same as i_* for the dcache
- mem_read, mem_write  out  1 each  memory command, level
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  LINE_W  latched write data
- mem_rdata  in  LINE_W  memory read data, valid with mem_resp
- mem_resp  in  1  memory done, 1-cycle pulse
- err  out  1  watchdog abort, 1-cycle pulse, coincident with the aborted requester's resp

## Operation
- Requester protocol:
  - Hold rd or wr high, with addr and wdata stable, until its resp pulse.
  - Drop the request in the cycle after resp.
  - rd and wr together is illegal; write takes precedence.
- States:
  - **IDLE**
    - No request: stay in IDLE.
    - One requester active: grant it.
    - Both active: grant the requester not equal to `last`.
    - On grant: latch id, op, addr and wdata; set `last` to id; go to BUSY.
  - **BUSY**
    - mem_read or mem_write is held high per the latched op, with mem_addr/mem_wdata driven from the latches.
    - The watchdog counts up from 0.
    - mem_resp: for a read, capture mem_rdata into the granted requester's rdata register; go to DONE.
    - Count reaching TIMEOUT-1 without mem_resp: go to DONE with the abort flag set; rdata is not updated.
  - **DONE**
    - mem_read and mem_write are low.
    - The granted requester's resp is high; err is high if the abort flag is set.
    - Next state is always IDLE.
    - This state gives the requester one cycle to deassert, so a stale request is never re-granted.
- Reset:
  - `last` = icache, so the dcache wins the first tie.
  - Abort flag = 0; watchdog = 0.
- Outputs at reset: all 0, including rdata registers and mem_addr/mem_wdata.
- Reset mid-transaction: the next edge returns to IDLE with all outputs 0; the transaction is abandoned with no resp.
- mem_resp outside BUSY is ignored.
- The watchdog is cleared on entry to BUSY and saturates; no counter wrap is permitted.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Request first seen in IDLE at edge N: mem_read/mem_write is high from cycle N+1.
- mem_resp sampled at edge M: mem_* low and resp/rdata valid at M+1; IDLE at M+2. Earliest next grant is sampled at edge M+2, with the next memory command at M+3.
- rdata holds its value until that requester's next successful read.
- Minimum transaction length is 3 cycles (BUSY, DONE, IDLE).
- Abort: mem_* drops after TIMEOUT cycles in BUSY; resp and err pulse together in DONE.
- Round-robin fairness: with both requesters continuously active, grants alternate strictly D, I, D, I…

## Structure
- Package `mem_arb_pkg`:
  - state enum {IDLE, BUSY, DONE}
  - requester id enum {REQ_I, REQ_D}
  - op enum {OP_RD, OP_WR}
- Sub-module `mem_arb_watchdog`:
  - Inputs: clk, rst, clr, en.
  - Output: expired, asserted when count == TIMEOUT-1.
  - Counter width is $clog2(TIMEOUT).
- Top level: FSM, grant latches and the two rdata registers.

## Test plan
- Single read: d_rd=1, d_addr=0x100; memory responds 4 cycles after mem_read rises with mem_rdata=0xDEADBEEF… → mem_read high for exactly 4 cycles with mem_addr=0x100; d_resp pulses once; d_rdata=0xDEADBEEF…; i_resp stays 0.
- Tie after reset: i_rd and d_wr rise in the same cycle → the dcache write goes first (mem_write, d_addr). After d_resp, the icache read is granted at edge M+2 and i_resp follows.
- Continuous contention: both requesters re-request immediately for 6 transactions → grant order D, I, D, I, D, I; no requester is granted twice consecutively.
- Watchdog: TIMEOUT=8, i_rd issued, mem_resp never asserted → mem_read drops after 8 BUSY cycles; i_resp and err pulse together; i_rdata unchanged.
- Reset mid-BUSY: rst asserted 2 cycles into a write → all outputs 0 next cycle; no resp; a late mem_resp is ignored; a new request proceeds normally.
- Illegal request: d_rd=d_wr=1 → mem_write is issued, mem_read stays 0.
